// File: rtl/ps2_frame_receiver_if.sv
// Signal bundle between the PS/2 frame receiver and its keyboard/controller side.
// master drives the raw PS/2 lines and Borrar; slave is the receiver.
interface ps2_frame_receiver_if;
  logic       PS2Clk;
  logic       PS2Data;
  logic       Borrar;
  logic       NewDataKB;
  logic       EndTras;
  logic       ParityCoherente;
  logic       FrameError;
  logic [7:0] ScanCode;
  logic       TimeoutErr;

  modport master (
    output PS2Clk, PS2Data, Borrar,
    input  NewDataKB, EndTras, ParityCoherente, FrameError, ScanCode, TimeoutErr
  );

  modport slave (
    input  PS2Clk, PS2Data, Borrar,
    output NewDataKB, EndTras, ParityCoherente, FrameError, ScanCode, TimeoutErr
  );
endinterface

// File: rtl/ps2_frame_receiver.sv
// PS/2 11-bit frame receiver: synchronizes the keyboard lines, shifts bits LSB-first
// on PS2Clk falling edges, decodes the frame and discards stalled partial frames.
module ps2_frame_receiver #(
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter int unsigned TO_W           = 16
) (
  input  logic                 Clk,
  input  logic                 Reset,
  ps2_frame_receiver_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;

  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES);

  state_t            state, state_n;
  logic [2:0]        kclk_sync;
  logic [1:0]        kdat_sync;
  logic [2:0]        armed;
  logic [10:0]       shreg;
  logic [10:0]       frame_n;
  logic [3:0]        count;
  logic [TO_W-1:0]   tocnt;
  logic              fall, accept, timeout, clear, frame_err_n;

  // armed delays edge detection until all three clock stages hold real samples,
  // so releasing reset with PS2Clk low cannot look like a falling edge.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      kclk_sync <= '1;
      kdat_sync <= '1;
      armed     <= '0;
    end else begin
      kclk_sync <= {kclk_sync[1:0], bus.PS2Clk};
      kdat_sync <= {kdat_sync[0], bus.PS2Data};
      armed     <= {armed[1:0], 1'b1};
    end
  end

  assign fall = armed[2] & kclk_sync[2] & ~kclk_sync[1];

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n     = state;
    accept      = 1'b0;
    timeout     = 1'b0;
    clear       = 1'b0;
    frame_n     = {kdat_sync[1], shreg[10:1]};
    frame_err_n = frame_n[0] | ~frame_n[10];
    case (state)
      IDLE: begin
        if (fall) begin
          accept  = 1'b1;
          state_n = RECV;
        end
      end
      RECV: begin
        if (fall) begin
          accept = 1'b1;
          if (count == 4'd10) state_n = DONE;
        end else if (tocnt == TO_MAX) begin
          timeout = 1'b1;
          state_n = IDLE;
        end
      end
      DONE: begin
        if (bus.Borrar) begin
          clear   = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      shreg               <= '0;
      count               <= '0;
      tocnt               <= '0;
      bus.NewDataKB       <= 1'b0;
      bus.TimeoutErr      <= 1'b0;
      bus.EndTras         <= 1'b0;
      bus.ParityCoherente <= 1'b0;
      bus.FrameError      <= 1'b0;
      bus.ScanCode        <= '0;
    end else begin
      bus.NewDataKB  <= accept;
      bus.TimeoutErr <= timeout;

      if (accept) begin
        shreg <= frame_n;
        count <= count + 4'd1;
      end else if (timeout || clear) begin
        shreg <= '0;
        count <= '0;
      end

      if (state == RECV && !accept && !timeout) tocnt <= tocnt + 1'b1;
      else                                      tocnt <= '0;

      // Decode from the incoming frame so results line up with the EndTras rise.
      if (accept && state_n == DONE) begin
        bus.EndTras         <= 1'b1;
        bus.ScanCode        <= frame_n[8:1];
        bus.FrameError      <= frame_err_n;
        bus.ParityCoherente <= ~frame_err_n & (^frame_n[9:1]);
      end else if (clear) begin
        bus.EndTras         <= 1'b0;
        bus.FrameError      <= 1'b0;
        bus.ParityCoherente <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_frame_receiver.sv
// Directed bench for ps2_frame_receiver: table of frames plus hand-written
// sequences for timeout, mid-frame reset, reset with PS2Clk low and held Borrar.
module tb_ps2_frame_receiver;

  localparam int TO   = 50000;
  localparam int HALF = 8;

  typedef struct {
    logic [10:0] bits;
    logic [7:0]  sc;
    logic        pc;
    logic        fe;
  } vec_t;

  logic Clk;
  logic Reset;
  ps2_frame_receiver_if bus();

  ps2_frame_receiver #(.TIMEOUT_CYCLES(TO), .TO_W(16)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  int tests = 0;
  int fails = 0;

  // Monitor: only this block writes these counters.
  int   cyc = 0;
  int   nd_cnt = 0;
  int   to_cnt = 0;
  int   end_hi = 0;
  int   last_nd_cyc = 0;
  int   to_cyc = 0;
  logic last_pulse_end = 1'b0;

  always @(negedge Clk) begin
    cyc = cyc + 1;
    if (bus.NewDataKB === 1'b1) begin
      nd_cnt         = nd_cnt + 1;
      last_pulse_end = bus.EndTras;
      last_nd_cyc    = cyc;
    end
    if (bus.TimeoutErr === 1'b1) begin
      to_cnt = to_cnt + 1;
      to_cyc = cyc;
    end
    if (bus.EndTras === 1'b1) end_hi = end_hi + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests = tests + 1;
    if (act !== exp) begin
      fails = fails + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [10:0] mk(input logic st, input logic [7:0] d,
                                     input logic par, input logic sp);
    return {sp, par, d, st};
  endfunction

  task automatic send_bit(input logic b, output int lat);
    @(posedge Clk);
    #1 bus.PS2Data = b;
    repeat (HALF) @(posedge Clk);
    #1 bus.PS2Clk = 1'b0;
    lat = 0;
    for (int k = 1; k <= HALF; k++) begin
      @(posedge Clk);
      @(negedge Clk);
      if (bus.NewDataKB === 1'b1 && lat == 0) lat = k;
    end
    bus.PS2Clk = 1'b1;
  endtask

  task automatic send_frame(input logic [10:0] f, output int lat0);
    int l;
    lat0 = 0;
    for (int i = 0; i < 11; i++) begin
      send_bit(f[i], l);
      if (i == 0) lat0 = l;
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_nd"}, 32'(bus.NewDataKB), 32'd0);
    chk({tag, "_end"}, 32'(bus.EndTras), 32'd0);
    chk({tag, "_pc"}, 32'(bus.ParityCoherente), 32'd0);
    chk({tag, "_fe"}, 32'(bus.FrameError), 32'd0);
    chk({tag, "_sc"}, 32'(bus.ScanCode), 32'd0);
    chk({tag, "_to"}, 32'(bus.TimeoutErr), 32'd0);
  endtask

  vec_t vecs[9];

  initial begin
    int lat, base, ebase, tbase;
    logic [10:0] f;

    vecs[0] = '{mk(1'b0, 8'h1C, 1'b0, 1'b1), 8'h1C, 1'b1, 1'b0};
    vecs[1] = '{mk(1'b0, 8'h1C, 1'b1, 1'b1), 8'h1C, 1'b0, 1'b0};
    vecs[2] = '{mk(1'b0, 8'hF0, 1'b1, 1'b0), 8'hF0, 1'b0, 1'b1};
    vecs[3] = '{mk(1'b0, 8'hF0, 1'b1, 1'b1), 8'hF0, 1'b1, 1'b0};
    vecs[4] = '{mk(1'b1, 8'hA5, 1'b1, 1'b1), 8'hA5, 1'b0, 1'b1};
    vecs[5] = '{mk(1'b0, 8'h00, 1'b1, 1'b1), 8'h00, 1'b1, 1'b0};
    vecs[6] = '{mk(1'b0, 8'hFF, 1'b0, 1'b1), 8'hFF, 1'b0, 1'b0};
    vecs[7] = '{mk(1'b0, 8'h80, 1'b0, 1'b1), 8'h80, 1'b1, 1'b0};
    vecs[8] = '{mk(1'b0, 8'h01, 1'b1, 1'b1), 8'h01, 1'b0, 1'b0};

    Reset       = 1'b0;
    bus.PS2Clk  = 1'b1;
    bus.PS2Data = 1'b1;
    bus.Borrar  = 1'b0;
    repeat (4) @(posedge Clk);
    #1 chk_zero("rst");
    @(posedge Clk);
    #1 Reset = 1'b1;
    repeat (5) @(posedge Clk);

    for (int i = 0; i < 9; i++) begin
      base = nd_cnt;
      send_frame(vecs[i].bits, lat);
      repeat (3) @(negedge Clk);
      chk($sformatf("v%0d_lat", i), 32'(lat), 32'd3);
      chk($sformatf("v%0d_pulses", i), 32'(nd_cnt - base), 32'd11);
      chk($sformatf("v%0d_end_with_11th", i), 32'(last_pulse_end), 32'd1);
      chk($sformatf("v%0d_end", i), 32'(bus.EndTras), 32'd1);
      chk($sformatf("v%0d_sc", i), 32'(bus.ScanCode), 32'(vecs[i].sc));
      chk($sformatf("v%0d_pc", i), 32'(bus.ParityCoherente), 32'(vecs[i].pc));
      chk($sformatf("v%0d_fe", i), 32'(bus.FrameError), 32'(vecs[i].fe));
      // Twelfth edge while DONE must be ignored.
      send_bit(1'b0, lat);
      chk($sformatf("v%0d_12th_lat", i), 32'(lat), 32'd0);
      chk($sformatf("v%0d_12th_pulses", i), 32'(nd_cnt - base), 32'd11);
      @(posedge Clk);
      #1 bus.Borrar = 1'b1;
      @(posedge Clk);
      #1 bus.Borrar = 1'b0;
      chk($sformatf("v%0d_clr_end", i), 32'(bus.EndTras), 32'd0);
      chk($sformatf("v%0d_clr_pc", i), 32'(bus.ParityCoherente), 32'd0);
      chk($sformatf("v%0d_clr_fe", i), 32'(bus.FrameError), 32'd0);
      chk($sformatf("v%0d_clr_sc_hold", i), 32'(bus.ScanCode), 32'(vecs[i].sc));
      repeat (4) @(posedge Clk);
    end

    // Partial frame of 5 bits, then PS2Clk idle until timeout.
    base  = nd_cnt;
    tbase = to_cnt;
    f = mk(1'b0, 8'h55, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) send_bit(f[i], lat);
    for (int k = 0; k < TO + 200 && to_cnt == tbase; k++) @(negedge Clk);
    repeat (5) @(negedge Clk);
    chk("to_pulses", 32'(to_cnt - tbase), 32'd1);
    chk("to_delay", 32'(to_cyc - last_nd_cyc), 32'(TO + 1));
    chk("to_bits", 32'(nd_cnt - base), 32'd5);
    chk("to_end", 32'(bus.EndTras), 32'd0);
    base = nd_cnt;
    send_frame(mk(1'b0, 8'hF0, 1'b1, 1'b1), lat);
    repeat (3) @(negedge Clk);
    chk("to_next_pulses", 32'(nd_cnt - base), 32'd11);
    chk("to_next_end", 32'(bus.EndTras), 32'd1);
    chk("to_next_sc", 32'(bus.ScanCode), 32'hF0);
    chk("to_next_pc", 32'(bus.ParityCoherente), 32'd1);
    chk("to_next_fe", 32'(bus.FrameError), 32'd0);
    @(posedge Clk);
    #1 bus.Borrar = 1'b1;
    @(posedge Clk);
    #1 bus.Borrar = 1'b0;

    // Reset after 6 bits of a frame.
    f = mk(1'b0, 8'h3A, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) send_bit(f[i], lat);
    @(posedge Clk);
    #3 Reset = 1'b0;
    #1 chk_zero("mid_rst");
    repeat (3) @(posedge Clk);
    #1 Reset = 1'b1;
    @(negedge Clk);
    chk_zero("mid_rel");
    repeat (5) @(posedge Clk);
    base = nd_cnt;
    send_frame(vecs[0].bits, lat);
    repeat (3) @(negedge Clk);
    chk("mid_next_pulses", 32'(nd_cnt - base), 32'd11);
    chk("mid_next_sc", 32'(bus.ScanCode), 32'h1C);
    chk("mid_next_pc", 32'(bus.ParityCoherente), 32'd1);
    chk("mid_next_fe", 32'(bus.FrameError), 32'd0);
    @(posedge Clk);
    #1 bus.Borrar = 1'b1;
    @(posedge Clk);
    #1 bus.Borrar = 1'b0;

    // Reset released while PS2Clk is low: no false edge.
    bus.PS2Clk = 1'b0;
    repeat (4) @(posedge Clk);
    #1 Reset = 1'b0;
    repeat (3) @(posedge Clk);
    #1 Reset = 1'b1;
    base = nd_cnt;
    repeat (10) @(negedge Clk);
    chk("lowclk_no_edge", 32'(nd_cnt - base), 32'd0);
    bus.PS2Clk = 1'b1;
    repeat (6) @(posedge Clk);
    send_frame(vecs[7].bits, lat);
    repeat (3) @(negedge Clk);
    chk("lowclk_pulses", 32'(nd_cnt - base), 32'd11);
    chk("lowclk_sc", 32'(bus.ScanCode), 32'h80);
    chk("lowclk_pc", 32'(bus.ParityCoherente), 32'd1);
    @(posedge Clk);
    #1 bus.Borrar = 1'b1;
    @(posedge Clk);
    #1 bus.Borrar = 1'b0;
    repeat (3) @(posedge Clk);

    // Borrar held high for a whole frame.
    #1 bus.Borrar = 1'b1;
    base  = nd_cnt;
    ebase = end_hi;
    send_frame(vecs[3].bits, lat);
    repeat (5) @(negedge Clk);
    chk("hold_pulses", 32'(nd_cnt - base), 32'd11);
    chk("hold_end_with_11th", 32'(last_pulse_end), 32'd1);
    chk("hold_end_cycles", 32'(end_hi - ebase), 32'd1);
    chk("hold_end_now", 32'(bus.EndTras), 32'd0);
    chk("hold_sc", 32'(bus.ScanCode), 32'hF0);
    bus.Borrar = 1'b0;
    repeat (3) @(posedge Clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
